// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared opcode, state and control-select encodings for the RV32I control path
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ST_RESET    = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEMADR   = 4'd3,
    ST_MEMREAD  = 4'd4,
    ST_MEMWB    = 4'd5,
    ST_MEMWRITE = 4'd6,
    ST_EXEC_R   = 4'd7,
    ST_EXEC_I   = 4'd8,
    ST_ALUWB    = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JAL      = 4'd11,
    ST_JALR     = 4'd12,
    ST_LUI      = 4'd13
  } state_t;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS1    = 2'b01;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b10;
  localparam logic [1:0] SRC_A_ZERO   = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] MEM_TO_REG_ALUOUT = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MDR    = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC     = 2'b10;

  localparam logic [1:0] ALU_CO_ADD    = 2'b00;
  localparam logic [1:0] ALU_CO_BRANCH = 2'b01;
  localparam logic [1:0] ALU_CO_FUNC   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       iord;
    logic       memory_read;
    logic       memory_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_co;
    logic       is_immediate;
  } ctrl_t;

  // Moore outputs for a state; the mem_ready-gated FETCH strobes are added in the top.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.memory_read = 1'b1;
        c.alu_src_a   = SRC_A_PC;
        c.alu_src_b   = SRC_B_FOUR;
        c.alu_co      = ALU_CO_ADD;
      end
      ST_DECODE: begin
        c.alu_src_a = SRC_A_OLD_PC;
        c.alu_src_b = SRC_B_IMM;
        c.alu_co    = ALU_CO_ADD;
      end
      ST_MEMADR: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_co    = ALU_CO_ADD;
      end
      ST_MEMREAD: begin
        c.memory_read = 1'b1;
        c.iord        = 1'b1;
      end
      ST_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = MEM_TO_REG_MDR;
      end
      ST_MEMWRITE: begin
        c.memory_write = 1'b1;
        c.iord         = 1'b1;
      end
      ST_EXEC_R: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_RS2;
        c.alu_co    = ALU_CO_FUNC;
      end
      ST_EXEC_I: begin
        c.alu_src_a    = SRC_A_RS1;
        c.alu_src_b    = SRC_B_IMM;
        c.alu_co       = ALU_CO_FUNC;
        c.is_immediate = 1'b1;
      end
      ST_ALUWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = MEM_TO_REG_ALUOUT;
      end
      ST_BRANCH: begin
        c.alu_src_a     = SRC_A_RS1;
        c.alu_src_b     = SRC_B_RS2;
        c.alu_co        = ALU_CO_BRANCH;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 1'b1;
      end
      ST_JAL: begin
        c.pc_write   = 1'b1;
        c.pc_source  = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_to_reg = MEM_TO_REG_PC;
      end
      ST_JALR: begin
        c.alu_src_a  = SRC_A_RS1;
        c.alu_src_b  = SRC_B_IMM;
        c.alu_co     = ALU_CO_ADD;
        c.pc_write   = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_to_reg = MEM_TO_REG_PC;
      end
      ST_LUI: begin
        c.alu_src_a = SRC_A_ZERO;
        c.alu_src_b = SRC_B_IMM;
        c.alu_co    = ALU_CO_ADD;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RV32I main control FSM
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] instruction_opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       pc_source_o,
  output logic       iord_o,
  output logic       memory_read_o,
  output logic       memory_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic [1:0] mem_to_reg_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] ALU_CO_o,
  output logic       is_immediate_o,
  output logic       illegal_instr_o,
  output logic [3:0] state_o
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl_q;
  logic   opcode_known;

  always_comb begin
    next_state   = ST_FETCH;
    opcode_known = 1'b1;
    case (state)
      ST_RESET:    next_state = ST_FETCH;
      ST_FETCH:    next_state = mem_ready_i ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (instruction_opcode_i)
          OP_LOAD, OP_STORE: next_state = ST_MEMADR;
          OP_RTYPE:          next_state = ST_EXEC_R;
          OP_ITYPE:          next_state = ST_EXEC_I;
          OP_BRANCH:         next_state = ST_BRANCH;
          OP_JAL:            next_state = ST_JAL;
          OP_JALR:           next_state = ST_JALR;
          OP_LUI:            next_state = ST_LUI;
          OP_AUIPC:          next_state = ST_ALUWB;
          default: begin
            next_state   = ST_FETCH;
            opcode_known = 1'b0;
          end
        endcase
      end
      // Only loads and stores reach here, so anything but a store is treated as a load.
      ST_MEMADR:   next_state = (instruction_opcode_i == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD:  next_state = mem_ready_i ? ST_MEMWB : ST_MEMREAD;
      ST_MEMWB:    next_state = ST_FETCH;
      ST_MEMWRITE: next_state = mem_ready_i ? ST_FETCH : ST_MEMWRITE;
      ST_EXEC_R:   next_state = ST_ALUWB;
      ST_EXEC_I:   next_state = ST_ALUWB;
      ST_ALUWB:    next_state = ST_FETCH;
      ST_BRANCH:   next_state = ST_FETCH;
      ST_JAL:      next_state = ST_FETCH;
      ST_JALR:     next_state = ST_FETCH;
      ST_LUI:      next_state = ST_ALUWB;
      default:     next_state = ST_FETCH;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_RESET;
      ctrl_q <= '0;
    end else begin
      state  <= next_state;
      ctrl_q <= state_ctrl(next_state);
    end
  end

  assign pc_write_o      = ctrl_q.pc_write | ((state == ST_FETCH) & mem_ready_i);
  assign ir_write_o      = (state == ST_FETCH) & mem_ready_i;
  assign illegal_instr_o = (state == ST_DECODE) & ~opcode_known;
  assign pc_write_cond_o = ctrl_q.pc_write_cond;
  assign pc_source_o     = ctrl_q.pc_source;
  assign iord_o          = ctrl_q.iord;
  assign memory_read_o   = ctrl_q.memory_read;
  assign memory_write_o  = ctrl_q.memory_write;
  assign reg_write_o     = ctrl_q.reg_write;
  assign mem_to_reg_o    = ctrl_q.mem_to_reg;
  assign alu_src_a_o     = ctrl_q.alu_src_a;
  assign alu_src_b_o     = ctrl_q.alu_src_b;
  assign ALU_CO_o        = ctrl_q.alu_co;
  assign is_immediate_o  = ctrl_q.is_immediate;
  assign state_o         = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, pc_source, iord, memory_read, memory_write;
  logic       ir_write, reg_write, is_immediate, illegal_instr;
  logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_co;
  logic [3:0] state;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic       chk_en = 1'b0;
  logic       probe  = 1'b0;
  logic [3:0] exp_state = 4'd0;
  logic [6:0] pin_q[$];
  int         path[$];

  multicycle_control_unit dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .instruction_opcode_i (opcode),
    .mem_ready_i          (mem_ready),
    .pc_write_o           (pc_write),
    .pc_write_cond_o      (pc_write_cond),
    .pc_source_o          (pc_source),
    .iord_o               (iord),
    .memory_read_o        (memory_read),
    .memory_write_o       (memory_write),
    .ir_write_o           (ir_write),
    .reg_write_o          (reg_write),
    .mem_to_reg_o         (mem_to_reg),
    .alu_src_a_o          (alu_src_a),
    .alu_src_b_o          (alu_src_b),
    .ALU_CO_o             (alu_co),
    .is_immediate_o       (is_immediate),
    .illegal_instr_o      (illegal_instr),
    .state_o              (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] dut_vec;
  assign dut_vec = {pc_write, pc_write_cond, pc_source, iord, memory_read, memory_write,
                    ir_write, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_co,
                    is_immediate, illegal_instr};

  function automatic logic known_op(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  endfunction

  // Output table written straight from the per-state behaviour list.
  function automatic logic [17:0] exp_vec(input logic [3:0] s, input logic rdy, input logic [6:0] op);
    logic pcw = 0, pwc = 0, psrc = 0, ad = 0, mr = 0, mw = 0, irw = 0, rw = 0, imm = 0, ill = 0;
    logic [1:0] m2r = 0, sa = 0, sb = 0, co = 0;
    case (s)
      4'd1:  begin mr = 1; sb = 2'b01; pcw = rdy; irw = rdy; end
      4'd2:  begin sa = 2'b10; sb = 2'b10; ill = !known_op(op); end
      4'd3:  begin sa = 2'b01; sb = 2'b10; end
      4'd4:  begin mr = 1; ad = 1; end
      4'd5:  begin rw = 1; m2r = 2'b01; end
      4'd6:  begin mw = 1; ad = 1; end
      4'd7:  begin sa = 2'b01; co = 2'b10; end
      4'd8:  begin sa = 2'b01; sb = 2'b10; co = 2'b10; imm = 1; end
      4'd9:  begin rw = 1; end
      4'd10: begin sa = 2'b01; co = 2'b01; pwc = 1; psrc = 1; end
      4'd11: begin pcw = 1; psrc = 1; rw = 1; m2r = 2'b10; end
      4'd12: begin sa = 2'b01; sb = 2'b10; pcw = 1; rw = 1; m2r = 2'b10; end
      4'd13: begin sa = 2'b11; sb = 2'b10; end
      default: ;
    endcase
    return {pcw, pwc, psrc, ad, mr, mw, irw, rw, m2r, sa, sb, co, imm, ill};
  endfunction

  task automatic build_path(input logic [6:0] op);
    case (op)
      7'b0000011: path = '{1, 2, 3, 4, 5};
      7'b0100011: path = '{1, 2, 3, 6};
      7'b0110011: path = '{1, 2, 7, 9};
      7'b0010011: path = '{1, 2, 8, 9};
      7'b1100011: path = '{1, 2, 10};
      7'b1101111: path = '{1, 2, 11};
      7'b1100111: path = '{1, 2, 12};
      7'b0110111: path = '{1, 2, 13, 9};
      7'b0010111: path = '{1, 2, 9};
      default:    path = '{1, 2};
    endcase
  endtask

  // Single checker: model on every negedge, hand-pinned literals, and the async reset probe.
  always @(negedge clk or posedge probe) begin
    if (probe) begin
      n_cmp++;
      if (state !== 4'd0 || dut_vec !== 18'd0)
        $display("FAIL async_reset: state=%0d outs=%b, want state=0 outs=0", state, dut_vec);
      if (state !== 4'd0 || dut_vec !== 18'd0) n_fail++;
    end else if (chk_en) begin
      n_cmp++;
      if (state !== exp_state) begin
        n_fail++;
        $display("FAIL state: got %0d want %0d", state, exp_state);
      end
      n_cmp++;
      if (dut_vec !== exp_vec(exp_state, mem_ready, opcode)) begin
        n_fail++;
        $display("FAIL outs@state%0d: got %b want %b", exp_state, dut_vec,
                 exp_vec(exp_state, mem_ready, opcode));
      end
      if (pin_q.size() > 0) begin
        n_cmp++;
        if ({alu_co, illegal_instr, state} !== pin_q[0]) begin
          n_fail++;
          $display("FAIL pinned{co,ill,state}: got %b want %b", {alu_co, illegal_instr, state}, pin_q[0]);
        end
        void'(pin_q.pop_front());
      end
    end
  end

  task automatic drive(input int s, input logic rdy, input logic [6:0] op);
    opcode    = op;
    mem_ready = rdy;
    exp_state = 4'(s);
    chk_en    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] op, input int fetch_wait, input int mem_wait);
    int n;
    logic mem_state;
    build_path(op);
    foreach (path[i]) begin
      mem_state = (path[i] == 1 || path[i] == 4 || path[i] == 6);
      n = mem_state ? ((path[i] == 1 ? fetch_wait : mem_wait) + 1) : 1;
      for (int k = 0; k < n; k++)
        drive(path[i], mem_state ? (k == n - 1) : 1'($urandom_range(0, 1)), op);
    end
  endtask

  task automatic pin(input logic [1:0] co, input logic ill, input logic [3:0] s);
    pin_q.push_back({co, ill, s});
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 7'd0;
    mem_ready = 1'b0;
    #3 probe = 1'b1;
    #1 probe = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 1'b1, 7'b0110011);

    pin(2'b00, 0, 1); pin(2'b00, 0, 2); pin(2'b10, 0, 7); pin(2'b00, 0, 9);
    run_instr(7'b0110011, 0, 0);

    pin(2'b00, 0, 1); pin(2'b00, 0, 1); pin(2'b00, 0, 1); pin(2'b00, 0, 2); pin(2'b00, 0, 3);
    for (int i = 0; i < 4; i++) pin(2'b00, 0, 4);
    pin(2'b00, 0, 5);
    run_instr(7'b0000011, 2, 3);

    run_instr(7'b0100011, 0, 1);
    pin(2'b00, 0, 1); pin(2'b00, 0, 2); pin(2'b01, 0, 10);
    run_instr(7'b1100011, 0, 0);
    run_instr(7'b0010011, 1, 0);
    pin(2'b00, 0, 1); pin(2'b00, 0, 2); pin(2'b00, 0, 9);
    run_instr(7'b0010111, 0, 0);
    run_instr(7'b1101111, 0, 0);
    run_instr(7'b1100111, 0, 0);
    run_instr(7'b0110111, 0, 0);
    pin(2'b00, 0, 1); pin(2'b00, 1, 2); pin(2'b00, 0, 1);
    run_instr(7'b1111111, 0, 0);
    run_instr(7'b0110011, 0, 0);
    run_instr(7'b0000000, 0, 2);

    // Store stalled in MEMWRITE, then reset lands between clock edges.
    drive(1, 1'b1, 7'b0100011);
    drive(2, 1'b1, 7'b0100011);
    drive(3, 1'b1, 7'b0100011);
    drive(6, 1'b0, 7'b0100011);
    drive(6, 1'b0, 7'b0100011);
    chk_en = 1'b0;
    #1 rst_n = 1'b0;
    #1 probe = 1'b1;
    #1 probe = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    pin(2'b00, 0, 1); pin(2'b00, 0, 2); pin(2'b10, 0, 8); pin(2'b00, 0, 9);
    run_instr(7'b0010011, 0, 0);
    run_instr(7'b0110011, 0, 0);
    chk_en = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
